// File: rtl/if_fetch_unit_pkg.sv
// Shared settings for the instruction-fetch front end: datapath width, reset PC
// and the fetch FSM state encoding.
package if_fetch_unit_pkg;

  localparam int unsigned DefaultWordWidth = 32;
  localparam logic [DefaultWordWidth-1:0] DefaultResetPc = '0;

  typedef enum logic [1:0] {
    StFetch = 2'd0,
    StReady = 2'd1,
    StDrain = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch-unit boundary: instruction-memory req/ack port, hazard/redirect inputs
// and the fetched-instruction outputs toward the IF pipeline register.
interface if_fetch_unit_if #(
  parameter int unsigned WORD_WIDTH = 32
);

  logic                  freeze;
  logic                  branch_taken;
  logic [WORD_WIDTH-1:0] branch_addr;
  logic                  imem_req;
  logic [WORD_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [WORD_WIDTH-1:0] imem_rdata;
  logic [WORD_WIDTH-1:0] pc_out;
  logic [WORD_WIDTH-1:0] instruction_out;
  logic                  fetch_valid;
  logic                  fetch_stall;

  // Fetch-unit side.
  modport master (
    input  freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
    output imem_req, imem_addr, pc_out, instruction_out, fetch_valid, fetch_stall
  );

  // Environment side: memory, hazard unit, EXE and IF register.
  modport slave (
    output freeze, branch_taken, branch_addr, imem_ack, imem_rdata,
    input  imem_req, imem_addr, pc_out, instruction_out, fetch_valid, fetch_stall
  );

endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, runs the req/ack memory port and
// buffers one fetched instruction until the IF register takes it.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned           WORD_WIDTH = DefaultWordWidth,
  parameter logic [WORD_WIDTH-1:0] RESET_PC   = DefaultResetPc
) (
  input logic           clk,
  input logic           rst,
  if_fetch_unit_if.master bus
);

  fetch_state_e          state_q, state_d;
  logic [WORD_WIDTH-1:0] pc_q, pc_d;
  logic [WORD_WIDTH-1:0] redirect_pc_q, redirect_pc_d;
  logic [WORD_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [WORD_WIDTH-1:0] instr_q, instr_d;

  logic                  req;
  logic                  ack;
  logic [WORD_WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + WORD_WIDTH'(4);
  // An ack only counts against a request we are actually driving.
  assign ack      = req & bus.imem_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      redirect_pc_q <= '0;
      pc_out_q      <= '0;
      instr_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      redirect_pc_q <= redirect_pc_d;
      pc_out_q      <= pc_out_d;
      instr_q       <= instr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    redirect_pc_d = redirect_pc_q;
    pc_out_d      = pc_out_q;
    instr_d       = instr_q;
    if (bus.branch_taken) begin
      // A request left hanging must be drained at its old address before redirecting.
      if (!req || ack) begin
        pc_d    = bus.branch_addr;
        state_d = StFetch;
      end else begin
        redirect_pc_d = bus.branch_addr;
        state_d       = StDrain;
      end
    end else begin
      unique case (state_q)
        StFetch: begin
          if (ack) begin
            instr_d  = bus.imem_rdata;
            pc_out_d = pc_plus4;
            pc_d     = pc_plus4;
            state_d  = StReady;
          end
        end
        StReady: begin
          if (!bus.freeze) begin
            if (ack) begin
              instr_d  = bus.imem_rdata;
              pc_out_d = pc_plus4;
              pc_d     = pc_plus4;
            end else begin
              state_d = StFetch;
            end
          end
        end
        StDrain: begin
          if (ack) begin
            pc_d    = redirect_pc_q;
            state_d = StFetch;
          end
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    req = 1'b0;
    if (rst) begin
      unique case (state_q)
        StFetch: req = 1'b1;
        StReady: req = ~bus.freeze;
        StDrain: req = 1'b1;
        default: req = 1'b0;
      endcase
    end
  end

  assign bus.imem_req        = req;
  assign bus.imem_addr       = pc_q;
  assign bus.pc_out          = pc_out_q;
  assign bus.instruction_out = instr_q;
  assign bus.fetch_valid     = (state_q == StReady);
  assign bus.fetch_stall     = (state_q != StReady);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table plus a zero-wait
// streaming sequence with a bounded wait.
module tb_if_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  typedef struct {
    logic        rst;
    logic        freeze;
    logic        br;
    logic [31:0] baddr;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
  } vec_t;

  logic clk;
  logic rst;
  logic tie;
  logic ack_v;
  logic [31:0] rdata_v;
  int errors;
  int checks;
  vec_t vecs[$];

  if_fetch_unit_if #(.WORD_WIDTH(32)) bus ();

  if_fetch_unit #(.WORD_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: either tied zero-wait or driven per vector.
  always_comb begin
    bus.imem_ack   = tie ? bus.imem_req : ack_v;
    bus.imem_rdata = tie ? (bus.imem_addr ^ K) : rdata_v;
  end

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ K;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic b, input logic [31:0] ba,
                     input logic a, input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.freeze = f; v.br = b; v.baddr = ba; v.ack = a;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_ins = ei;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_pc;
    bit          seen;
    errors = 0;
    checks = 0;
    tie = 1'b0;
    ack_v = 1'b0;
    rdata_v = '0;
    rst = 1'b0;
    bus.freeze = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr = '0;

    //   rst fr br baddr         ack req addr          vld pc_out        instr
    add(0, 0, 0, 0,            0,  0,  32'h0,        0,  32'h0,        32'h0);         // reset
    add(1, 0, 0, 0,            1,  1,  32'h0,        0,  32'h0,        32'h0);         // zero-wait
    add(1, 0, 0, 0,            1,  1,  32'h4,        1,  32'h4,        ins(32'h0));
    add(1, 0, 0, 0,            1,  1,  32'h8,        1,  32'h8,        ins(32'h4));
    add(1, 0, 0, 0,            1,  1,  32'hC,        1,  32'hC,        ins(32'h8));
    add(1, 0, 0, 0,            0,  1,  32'h10,       1,  32'h10,       ins(32'hC));    // miss
    add(1, 0, 0, 0,            0,  1,  32'h10,       0,  32'h10,       ins(32'hC));
    add(1, 0, 0, 0,            1,  1,  32'h10,       0,  32'h10,       ins(32'hC));
    add(1, 1, 0, 0,            0,  0,  32'h14,       1,  32'h14,       ins(32'h10));   // freeze
    add(1, 1, 0, 0,            0,  0,  32'h14,       1,  32'h14,       ins(32'h10));
    add(1, 1, 0, 0,            1,  0,  32'h14,       1,  32'h14,       ins(32'h10));   // stray ack
    add(1, 1, 0, 0,            0,  0,  32'h14,       1,  32'h14,       ins(32'h10));
    add(1, 1, 0, 0,            0,  0,  32'h14,       1,  32'h14,       ins(32'h10));
    add(1, 0, 0, 0,            1,  1,  32'h14,       1,  32'h14,       ins(32'h10));
    add(1, 0, 0, 0,            0,  1,  32'h18,       1,  32'h18,       ins(32'h14));
    add(1, 0, 1, 32'h100,      0,  1,  32'h18,       0,  32'h18,       ins(32'h14));   // -> drain
    add(1, 0, 0, 0,            0,  1,  32'h18,       0,  32'h18,       ins(32'h14));
    add(1, 0, 0, 0,            1,  1,  32'h18,       0,  32'h18,       ins(32'h14));   // dropped
    add(1, 0, 0, 0,            1,  1,  32'h100,      0,  32'h18,       ins(32'h14));
    add(1, 0, 0, 0,            0,  1,  32'h104,      1,  32'h104,      ins(32'h100));
    add(1, 0, 1, 32'h200,      0,  1,  32'h104,      0,  32'h104,      ins(32'h100));  // two in drain
    add(1, 0, 1, 32'h300,      0,  1,  32'h104,      0,  32'h104,      ins(32'h100));
    add(1, 0, 0, 0,            1,  1,  32'h104,      0,  32'h104,      ins(32'h100));
    add(1, 0, 0, 0,            1,  1,  32'h300,      0,  32'h104,      ins(32'h100));
    add(1, 0, 1, 32'h400,      1,  1,  32'h304,      1,  32'h304,      ins(32'h300));  // br + ack
    add(1, 0, 0, 0,            0,  1,  32'h400,      0,  32'h304,      ins(32'h300));
    add(1, 0, 0, 0,            1,  1,  32'h400,      0,  32'h304,      ins(32'h300));
    add(1, 1, 1, 32'h500,      0,  0,  32'h404,      1,  32'h404,      ins(32'h400));  // br frozen
    add(1, 0, 0, 0,            1,  1,  32'h500,      0,  32'h404,      ins(32'h400));
    add(1, 0, 0, 0,            0,  1,  32'h504,      1,  32'h504,      ins(32'h500));
    add(1, 0, 1, 32'h600,      0,  1,  32'h504,      0,  32'h504,      ins(32'h500));
    add(1, 0, 1, 32'h700,      1,  1,  32'h504,      0,  32'h504,      ins(32'h500));  // drain br+ack
    add(1, 0, 0, 0,            1,  1,  32'h700,      0,  32'h504,      ins(32'h500));
    add(1, 0, 1, 32'hFFFFFFFC, 1,  1,  32'h704,      1,  32'h704,      ins(32'h700));
    add(1, 0, 0, 0,            1,  1,  32'hFFFFFFFC, 0,  32'h704,      ins(32'h700));
    add(1, 0, 0, 0,            1,  1,  32'h0,        1,  32'h0,        ins(32'hFFFFFFFC)); // wrap
    add(0, 0, 0, 0,            0,  0,  32'h4,        1,  32'h4,        ins(32'h0));    // mid reset
    add(0, 0, 0, 0,            1,  0,  32'h0,        0,  32'h0,        32'h0);
    add(1, 0, 0, 0,            0,  1,  32'h0,        0,  32'h0,        32'h0);         // 3-cycle ack
    add(1, 0, 0, 0,            0,  1,  32'h0,        0,  32'h0,        32'h0);
    add(1, 0, 0, 0,            1,  1,  32'h0,        0,  32'h0,        32'h0);
    add(1, 0, 0, 0,            0,  1,  32'h4,        1,  32'h4,        ins(32'h0));
    add(1, 0, 0, 0,            0,  1,  32'h4,        0,  32'h4,        ins(32'h0));

    @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      #1;
      rst              = vecs[i].rst;
      bus.freeze       = vecs[i].freeze;
      bus.branch_taken = vecs[i].br;
      bus.branch_addr  = vecs[i].baddr;
      ack_v            = vecs[i].ack;
      rdata_v          = vecs[i].e_addr ^ K;
      @(negedge clk);
      chk($sformatf("v%0d req", i),   {31'b0, bus.imem_req},    {31'b0, vecs[i].e_req});
      chk($sformatf("v%0d addr", i),  bus.imem_addr,            vecs[i].e_addr);
      chk($sformatf("v%0d valid", i), {31'b0, bus.fetch_valid}, {31'b0, vecs[i].e_valid});
      chk($sformatf("v%0d stall", i), {31'b0, bus.fetch_stall}, {31'b0, ~vecs[i].e_valid});
      chk($sformatf("v%0d pc_out", i), bus.pc_out,              vecs[i].e_pc);
      chk($sformatf("v%0d instr", i), bus.instruction_out,      vecs[i].e_ins);
      @(posedge clk);
    end

    // Zero-wait stream from the pending fetch at 0x4: one instruction per cycle.
    #1;
    bus.branch_taken = 1'b0;
    bus.freeze = 1'b0;
    tie = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clk);
      seen = bus.fetch_valid;
    end
    chk("stream valid_within_budget", {31'b0, seen}, 32'd1);
    exp_pc = 32'h8;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("stream%0d pc_out", k), bus.pc_out, exp_pc);
      chk($sformatf("stream%0d instr", k), bus.instruction_out, ins(exp_pc - 32'h4));
      chk($sformatf("stream%0d valid", k), {31'b0, bus.fetch_valid}, 32'd1);
      exp_pc = exp_pc + 32'h4;
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
